// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - state encoding and shared constants for gray_step_arbiter
package gray_arb_pkg;

    localparam int GRAY_W_DEFAULT = 3;

    // Last code of a reflected gray sequence: MSB set, all other bits clear.
    localparam logic [GRAY_W_DEFAULT-1:0] GRAY_LAST_CODE = {1'b1, {(GRAY_W_DEFAULT-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gray_rr_pick.sv
// rtl/gray_rr_pick.sv - combinational 2-way picker, round-robin or fixed priority (GRAY_ARB_FIXED_PRIO_EN)
module gray_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

`ifdef GRAY_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        pick = 2'b00;
        if (req[0]) begin
            pick = 2'b01;
        end else if (req[1]) begin
            pick = 2'b10;
        end
    end
`else
    // A lone or absent request passes straight through; only a tie consults the pointer.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/gray_step_arbiter.sv
// rtl/gray_step_arbiter.sv - shares one gray counter between two step-count requesters (option: GRAY_ARB_FIXED_PRIO_EN)
module gray_step_arbiter
    import gray_arb_pkg::*;
#(
    parameter int GRAY_W = GRAY_W_DEFAULT,
    parameter int STEP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        Req,
    input  logic [1:0]        ClrFirst,
    input  logic [STEP_W-1:0] Steps0,
    input  logic [STEP_W-1:0] Steps1,
    output logic [1:0]        Gnt,
    output logic [1:0]        Done,
    output logic [STEP_W-1:0] Wraps,
    output logic [GRAY_W-1:0] ResultGray,
    output logic              OvfSeen,
    output logic              CntEn,
    output logic              CntClr,
    input  logic [GRAY_W-1:0] CntValue,
    input  logic              CntOverflow
);

    localparam logic [GRAY_W-1:0] LAST_CODE = {1'b1, {(GRAY_W-1){1'b0}}};

    arb_state_t        state, state_nxt;
    logic [1:0]        pick;
    logic              pick_idx;
    logic [STEP_W-1:0] pick_steps;
    logic              winner;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] wrap_cnt;
    logic [GRAY_W-1:0] result_q;
    logic              ovf;
    logic              ptr;

    assign pick_idx   = pick[1];
    assign pick_steps = pick_idx ? Steps1 : Steps0;

    gray_rr_pick u_pick (
        .req  (Req),
        .ptr  (ptr),
        .pick (pick)
    );

`ifdef GRAY_ARB_FIXED_PRIO_EN
    assign ptr = 1'b0;
`else
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr <= 1'b0;
        end else if (state == DONE) begin
            ptr <= ~winner;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|pick) begin
                    if (ClrFirst[pick_idx]) begin
                        state_nxt = CLR;
                    end else if (pick_steps != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            CLR:     state_nxt = (remaining != '0) ? RUN : SETTLE;
            RUN:     if (remaining == STEP_W'(1)) state_nxt = SETTLE;
            SETTLE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job datapath: latched request, remaining steps, wrap count and sticky overflow.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            winner    <= 1'b0;
            remaining <= '0;
            wrap_cnt  <= '0;
            result_q  <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        winner    <= pick_idx;
                        remaining <= pick_steps;
                        wrap_cnt  <= '0;
                        ovf       <= 1'b0;
                    end
                end
                CLR: ovf <= ovf | CntOverflow;
                RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    ovf       <= ovf | CntOverflow;
                    if (CntValue == LAST_CODE && wrap_cnt != '1) begin
                        wrap_cnt <= wrap_cnt + STEP_W'(1);
                    end
                end
                SETTLE: begin
                    ovf      <= ovf | CntOverflow;
                    result_q <= CntValue;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Gnt        = 2'b00;
        Done       = 2'b00;
        CntEn      = 1'b0;
        CntClr     = 1'b0;
        Wraps      = '0;
        ResultGray = '0;
        OvfSeen    = 1'b0;
        if (state != IDLE) begin
            Gnt = idx_onehot(winner);
        end
        case (state)
            CLR: CntClr = 1'b1;
            RUN: CntEn  = 1'b1;
            DONE: begin
                Done       = idx_onehot(winner);
                Wraps      = wrap_cnt;
                ResultGray = result_q;
                OvfSeen    = ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb/tb_gray_step_arbiter.sv - job-level reference model bench for gray_step_arbiter (honours GRAY_ARB_FIXED_PRIO_EN)
module tb_gray_step_arbiter;

    localparam int GW = 3;
    localparam int SW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [1:0]    Req = 2'b00;
    logic [1:0]    ClrFirst = 2'b00;
    logic [SW-1:0] Steps0 = '0;
    logic [SW-1:0] Steps1 = '0;
    logic [1:0]    Gnt;
    logic [1:0]    Done;
    logic [SW-1:0] Wraps;
    logic [GW-1:0] ResultGray;
    logic          OvfSeen;
    logic          CntEn;
    logic          CntClr;
    logic [GW-1:0] CntValue;
    logic          CntOverflow = 1'b0;
    logic [GW-1:0] cnt_bin = '0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    gray_step_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .ClrFirst    (ClrFirst),
        .Steps0      (Steps0),
        .Steps1      (Steps1),
        .Gnt         (Gnt),
        .Done        (Done),
        .Wraps       (Wraps),
        .ResultGray  (ResultGray),
        .OvfSeen     (OvfSeen),
        .CntEn       (CntEn),
        .CntClr      (CntClr),
        .CntValue    (CntValue),
        .CntOverflow (CntOverflow)
    );

    // The shared counter the arbiter drives: binary count presented as gray.
    always @(posedge Clk) begin
        if (CntClr) begin
            cnt_bin <= '0;
        end else if (CntEn) begin
            cnt_bin <= cnt_bin + 1'b1;
        end
    end
    assign CntValue = cnt_bin ^ (cnt_bin >> 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is clr + steps + 2 granted cycles; clear first, then the
    // enabled steps, one settle cycle, and Done on the last one.
    initial begin : model
        bit busy, clr, ovf, e_clr, e_en, e_done;
        int c, len, w, steps, ptr, cnt, wraps;
        logic [1:0] oh;
        busy = 0; ptr = 0; cnt = 0; c = 0; len = 0; w = 0; steps = 0; wraps = 0;
        clr = 0; ovf = 0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                check("reset_outs", 32'({Gnt, Done, Wraps, ResultGray, OvfSeen, CntEn, CntClr}), 0);
                busy = 0;
                ptr = 0;
            end else if (!busy) begin
                check("idle_outs", 32'({Gnt, Done, CntEn, CntClr}), 0);
                if (Req != 2'b00) begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
                    w = Req[0] ? 0 : 1;
`else
                    w = (Req == 2'b11) ? ptr : (Req[1] ? 1 : 0);
`endif
                    clr   = ClrFirst[w];
                    steps = (w == 1) ? int'(Steps1) : int'(Steps0);
                    len   = int'(clr) + steps + 2;
                    c     = 0;
                    wraps = 0;
                    ovf   = 0;
                    busy  = 1;
                end
            end else begin
                oh     = (w == 1) ? 2'b10 : 2'b01;
                e_clr  = clr && (c == 0);
                e_en   = (c >= int'(clr)) && (c < int'(clr) + steps);
                e_done = (c == len - 1);
                check("gnt", 32'(Gnt), 32'(oh));
                check("cnt_clr", 32'(CntClr), 32'(e_clr));
                check("cnt_en", 32'(CntEn), 32'(e_en));
                check("done", 32'(Done), e_done ? 32'(oh) : 0);
                if (e_done) begin
                    check("result_gray", 32'(ResultGray), cnt ^ (cnt >> 1));
                    check("wraps", 32'(Wraps), wraps);
                    check("ovf_seen", 32'(OvfSeen), 32'(ovf));
                    busy = 0;
                    ptr  = 1 - w;
                end else begin
                    ovf = ovf | CntOverflow;
                end
                if (e_en && cnt == (1 << GW) - 1 && wraps < (1 << SW) - 1) wraps++;
                if (e_clr) cnt = 0;
                else if (e_en) cnt = (cnt + 1) % (1 << GW);
                c++;
            end
        end
    end

    task automatic wait_done(output int who, output int glen, output logic [GW-1:0] rg,
                             output logic [SW-1:0] wr);
        bit seen;
        seen = 0; who = -1; glen = 0; rg = '0; wr = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            if (Gnt != 2'b00) glen++;
            if (Done != 2'b00) begin
                seen = 1;
                who  = Done[1] ? 1 : 0;
                rg   = ResultGray;
                wr   = Wraps;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_job(input string tag, input logic [1:0] req, input logic [1:0] clr,
                           input logic [SW-1:0] s0, input logic [SW-1:0] s1, input int e_who,
                           input logic [GW-1:0] e_gray, input logic [SW-1:0] e_wraps, input int e_len);
        int who, glen;
        logic [GW-1:0] rg;
        logic [SW-1:0] wr;
        Req = req; ClrFirst = clr; Steps0 = s0; Steps1 = s1;
        wait_done(who, glen, rg, wr);
        check({tag, "_who"}, who, e_who);
        check({tag, "_gray"}, 32'(rg), 32'(e_gray));
        check({tag, "_wraps"}, 32'(wr), 32'(e_wraps));
        check({tag, "_len"}, glen, e_len);
        @(posedge Clk); #1;
        Req = 2'b00;
    endtask

    initial begin : stim
        int who, glen, en_seen, dcount, gnt_seen;
        logic [GW-1:0] rg;
        logic [SW-1:0] wr;
        int exp_who [3];
        logic [GW-1:0] exp_gray [3];
`ifdef GRAY_ARB_FIXED_PRIO_EN
        exp_who = '{0, 0, 0};
`else
        exp_who = '{0, 1, 0};
`endif
        exp_gray = '{3'b011, 3'b010, 3'b110};

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;

        // Clear then 5 steps ends on binary 5 = gray 111; 9 steps from 0 passes 100 once.
        run_job("clr5", 2'b01, 2'b01, 4'd5, 4'd0, 0, 3'b111, 4'd0, 8);
        run_job("clr9", 2'b10, 2'b10, 4'd0, 4'd9, 1, 3'b001, 4'd1, 12);

        Req = 2'b11; ClrFirst = 2'b00; Steps0 = 4'd1; Steps1 = 4'd1;
        for (int j = 0; j < 3; j++) begin
            wait_done(who, glen, rg, wr);
            check("alt_who", who, exp_who[j]);
            check("alt_gray", 32'(rg), 32'(exp_gray[j]));
            check("alt_len", glen, 3);
        end
        @(posedge Clk); #1;
        Req = 2'b00;

        run_job("prep2", 2'b01, 2'b01, 4'd2, 4'd0, 0, 3'b011, 4'd0, 5);
        run_job("zero", 2'b01, 2'b00, 4'd0, 4'd0, 0, 3'b011, 4'd0, 2);

        Req = 2'b01; ClrFirst = 2'b00; Steps0 = 4'd6;
        en_seen = 0;
        for (int i = 0; i < 50 && en_seen < 3; i++) begin
            @(negedge Clk);
            if (CntEn) en_seen++;
        end
        check("rst_en_seen", en_seen, 3);
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        check("rst_async", 32'({Gnt, Done, CntEn, CntClr}), 0);
        Req = 2'b11; Steps0 = 4'd1; Steps1 = 4'd1;
        @(posedge Clk);
        @(posedge Clk); #1;
        Reset = 1'b1;
        wait_done(who, glen, rg, wr);
        check("rst_ptr_who", who, 0);
        @(posedge Clk); #1;
        Req = 2'b00;

        @(posedge Clk); #1;
        Req = 2'b01; ClrFirst = 2'b00; Steps0 = 4'd4;
        gnt_seen = 0;
        for (int i = 0; i < 20 && gnt_seen == 0; i++) begin
            @(negedge Clk);
            if (Gnt[0]) gnt_seen = 1;
        end
        check("drop_gnt_seen", gnt_seen, 1);
        @(negedge Clk);
        @(posedge Clk); #1;
        Req = 2'b00;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done[0]) dcount++;
        end
        check("drop_done_count", dcount, 1);

        for (int i = 0; i < 1500; i++) begin
            @(posedge Clk); #1;
            if (!Reset) Reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) Reset = 1'b0;
            if ($urandom_range(0, 2) == 0) Req = 2'($urandom);
            if ($urandom_range(0, 3) == 0) ClrFirst = 2'($urandom);
            if ($urandom_range(0, 3) == 0) Steps0 = SW'($urandom);
            if ($urandom_range(0, 3) == 0) Steps1 = SW'($urandom);
            CntOverflow = ($urandom_range(0, 7) == 0);
        end

        @(posedge Clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
